katio_alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined ALU; successor to the single-bit KATIO_NAND2/KATIO_OR2/NOT1/EXOR2/KATIO_AND2 gate set.
- Adds WIDTH-bit operands, an opcode-selected operation set including arithmetic and shifts, carry/zero/error flags, and valid/ready handshakes on both sides.
- Sits between the operand source (register file / sequencer) and the writeback path.

---
 rtl/katio_alu_pkg.sv | 47 ++++
 rtl/katio_alu_core.sv | 70 +++++++
 rtl/katio_alu_pipe.sv | 151 +++++++++++++++
 tb/tb_katio_alu_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/katio_alu_pkg.sv
// ============================================================================
// Module      : katio_alu_pkg
// Description : Opcode encoding and shift carry-out helper for katio_alu_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package katio_alu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_AND    = 4'd0;
    localparam logic [OPW-1:0] OP_OR     = 4'd1;
    localparam logic [OPW-1:0] OP_NAND   = 4'd2;
    localparam logic [OPW-1:0] OP_NOR    = 4'd3;
    localparam logic [OPW-1:0] OP_EXOR   = 4'd4;
    localparam logic [OPW-1:0] OP_NOT    = 4'd5;
    localparam logic [OPW-1:0] OP_ADD    = 4'd6;
    localparam logic [OPW-1:0] OP_SUB    = 4'd7;
    localparam logic [OPW-1:0] OP_SHL    = 4'd8;
    localparam logic [OPW-1:0] OP_SHR    = 4'd9;
    localparam logic [OPW-1:0] OP_ACC    = 4'd10;
    localparam logic [OPW-1:0] OP_CLRACC = 4'd11;

    // Last bit pushed out by a shift of 'amt' places on a 'width'-bit value.
    // Amounts beyond the width (possible when width is not a power of two)
    // only shift out zeros, so the carry is 0 there.
    function automatic logic shift_carry(
        input logic [63:0] val,
        input logic [31:0] amt,
        input logic [31:0] width,
        input logic        dir_left
    );
        logic [5:0] idx;
        logic       c;
        c   = 1'b0;
        idx = '0;
        if ((amt != 32'd0) && (amt <= width)) begin
            idx = dir_left ? 6'(width - amt) : 6'(amt - 32'd1);
            c   = val[idx];
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/katio_alu_core.sv
// ============================================================================
// Module      : katio_alu_core
// Description : Combinational ALU datapath (gates, add/sub, shifts, optional
//               accumulator ops when KATIO_ALU_ACC_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module katio_alu_core
    import katio_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [OPW-1:0]   i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef KATIO_ALU_ACC_EN
    input  logic [WIDTH-1:0] i_acc,
`endif
    output logic [WIDTH-1:0] o_y,
    output logic             o_carry,
    output logic             o_err
);

    logic [WIDTH:0]   w_add;
    logic [SHW-1:0]   w_shamt;
`ifdef KATIO_ALU_ACC_EN
    logic [WIDTH:0]   w_acc_sum;
    assign w_acc_sum = {1'b0, i_acc} + {1'b0, i_a};
`endif

    assign w_add   = {1'b0, i_a} + {1'b0, i_b};
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_y     = '0;
        o_carry = 1'b0;
        o_err   = 1'b0;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_EXOR: o_y = i_a ^ i_b;
            OP_NOT:  o_y = ~i_a;
            OP_ADD:  {o_carry, o_y} = w_add;
            OP_SUB: begin
                o_y     = i_a - i_b;
                o_carry = (i_a >= i_b);
            end
            OP_SHL: begin
                o_y     = i_a << w_shamt;
                o_carry = shift_carry(64'(i_a), 32'(w_shamt), 32'(WIDTH), 1'b1);
            end
            OP_SHR: begin
                o_y     = i_a >> w_shamt;
                o_carry = shift_carry(64'(i_a), 32'(w_shamt), 32'(WIDTH), 1'b0);
            end
`ifdef KATIO_ALU_ACC_EN
            OP_ACC:    {o_carry, o_y} = w_acc_sum;
            OP_CLRACC: o_y = '0;
`endif
            default: o_err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/katio_alu_pipe.sv
// ============================================================================
// Module      : katio_alu_pipe
// Description : Two-stage valid/ready pipelined ALU. Optional accumulator
//               (ops ACC/CLRACC) is built when KATIO_ALU_ACC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module katio_alu_pipe
    import katio_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    logic             r_s1_valid_q, w_s1_valid_d;
    logic [OPW-1:0]   r_s1_op_q,    w_s1_op_d;
    logic [WIDTH-1:0] r_s1_a_q,     w_s1_a_d;
    logic [WIDTH-1:0] r_s1_b_q,     w_s1_b_d;
    logic             r_s2_valid_q, w_s2_valid_d;
    logic [WIDTH-1:0] r_y_q,        w_y_d;
    logic             r_carry_q,    w_carry_d;
    logic             r_zero_q,     w_zero_d;
    logic             r_err_q,      w_err_d;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_accept;
    logic [WIDTH-1:0] w_core_y;
    logic             w_core_carry;
    logic             w_core_err;

`ifdef KATIO_ALU_ACC_EN
    logic [WIDTH-1:0] r_acc_q, w_acc_d;
`endif

    katio_alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .i_op    (r_s1_op_q),
        .i_a     (r_s1_a_q),
        .i_b     (r_s1_b_q),
`ifdef KATIO_ALU_ACC_EN
        .i_acc   (r_acc_q),
`endif
        .o_y     (w_core_y),
        .o_carry (w_core_carry),
        .o_err   (w_core_err)
    );

    assign w_adv2   = !r_s2_valid_q || out_ready;
    assign w_adv1   = !r_s1_valid_q || w_adv2;
    // rst gating keeps the port low while reset is held; no in_valid path.
    assign in_ready = w_adv1 && !rst;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_s1_valid_d = r_s1_valid_q;
        w_s1_op_d    = r_s1_op_q;
        w_s1_a_d     = r_s1_a_q;
        w_s1_b_d     = r_s1_b_q;
        w_s2_valid_d = r_s2_valid_q;
        w_y_d        = r_y_q;
        w_carry_d    = r_carry_q;
        w_zero_d     = r_zero_q;
        w_err_d      = r_err_q;
`ifdef KATIO_ALU_ACC_EN
        w_acc_d      = r_acc_q;
`endif
        if (w_adv1) begin
            w_s1_valid_d = w_accept;
        end
        if (w_accept) begin
            w_s1_op_d = op;
            w_s1_a_d  = a;
            w_s1_b_d  = b;
        end
        if (w_adv2) begin
            w_s2_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_y_d     = w_core_y;
                w_carry_d = w_core_carry;
                w_zero_d  = (w_core_y == '0);
                w_err_d   = w_core_err;
`ifdef KATIO_ALU_ACC_EN
                // Commit only on the S1->S2 move so a stalled beat adds once.
                if (r_s1_op_q == OP_ACC) begin
                    w_acc_d = w_core_y;
                end else if (r_s1_op_q == OP_CLRACC) begin
                    w_acc_d = '0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q <= 1'b0;
            r_s1_op_q    <= '0;
            r_s1_a_q     <= '0;
            r_s1_b_q     <= '0;
            r_s2_valid_q <= 1'b0;
            r_y_q        <= '0;
            r_carry_q    <= 1'b0;
            r_zero_q     <= 1'b0;
            r_err_q      <= 1'b0;
`ifdef KATIO_ALU_ACC_EN
            r_acc_q      <= '0;
`endif
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s1_op_q    <= w_s1_op_d;
            r_s1_a_q     <= w_s1_a_d;
            r_s1_b_q     <= w_s1_b_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_y_q        <= w_y_d;
            r_carry_q    <= w_carry_d;
            r_zero_q     <= w_zero_d;
            r_err_q      <= w_err_d;
`ifdef KATIO_ALU_ACC_EN
            r_acc_q      <= w_acc_d;
`endif
        end
    end

    assign out_valid = r_s2_valid_q;
    assign y         = r_y_q;
    assign carry     = r_carry_q;
    assign zero      = r_zero_q;
    assign err       = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_katio_alu_pipe.sv
// ============================================================================
// Module      : tb_katio_alu_pipe
// Description : Directed self-checking bench for katio_alu_pipe (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_katio_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       carry;
    logic       zero;
    logic       err;

    int total = 0;
    int bad   = 0;

    katio_alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; op = 4'd6; a = 8'h01; b = 8'h01; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || y !== 8'h00 || err !== 1'b0 || carry !== 1'b0
                || zero !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_state c=%0d: ov=%b y=%h err=%b c=%b z=%b ir=%b, want 0 00 0 0 0 0",
                         c, out_valid, y, err, carry, zero, in_ready);
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL first_latency1: out_valid=%b want 0", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || y !== 8'h02 || carry !== 1'b0 || zero !== 1'b0) begin
            bad++;
            $display("FAIL first_result: ov=%b y=%h c=%b z=%b want 1 02 0 0", out_valid, y, carry, zero);
        end
        repeat (3) tick();
    endtask

    task automatic test_gate_ops();
        logic [7:0] ey [6];
        int k;
        ey = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h0F};
        k = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 6);
            op = 4'(c);
            a = 8'hF0; b = 8'h3C;
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL gate_in_ready c=%0d: %b want 1", c, in_ready);
            end
            if (out_valid === 1'b1) begin
                total++;
                if (k >= 6) begin
                    bad++; $display("FAIL gate_extra: unexpected result y=%h", y);
                end else begin
                    if (y !== ey[k] || carry !== 1'b0 || err !== 1'b0 || zero !== 1'b0 || c != k + 2) begin
                        bad++;
                        $display("FAIL gate_op%0d: y=%h c=%b e=%b z=%b cyc=%0d, want y=%h c=0 e=0 z=0 cyc=%0d",
                                 k, y, carry, err, zero, c, ey[k], k + 2);
                    end
                end
                k++;
            end
            tick();
        end
        total++;
        if (k !== 6) begin
            bad++; $display("FAIL gate_count: got %0d results want 6", k);
        end
    endtask

    task automatic test_arith_shift();
        logic [3:0] t_op [8];
        logic [7:0] t_a  [8];
        logic [7:0] t_b  [8];
        logic [7:0] ey   [8];
        logic       ec   [8];
        logic       ez   [8];
        logic       ee   [8];
        int k;
        t_op = '{4'd6,  4'd7,  4'd7,  4'd8,  4'd9,  4'd13, 4'd6,  4'd9};
        t_a  = '{8'hFF, 8'h05, 8'h07, 8'h81, 8'h81, 8'h55, 8'h12, 8'h81};
        t_b  = '{8'h01, 8'h07, 8'h07, 8'h01, 8'h00, 8'h33, 8'h34, 8'h01};
        ey   = '{8'h00, 8'hFE, 8'h00, 8'h02, 8'h81, 8'h00, 8'h46, 8'h40};
        ec   = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
        ez   = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
        ee   = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
        k = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            if (c < 8) begin
                op = t_op[c]; a = t_a[c]; b = t_b[c];
            end
            #1;
            if (out_valid === 1'b1) begin
                total++;
                if (k >= 8) begin
                    bad++; $display("FAIL arith_extra: unexpected result y=%h", y);
                end else if (y !== ey[k] || carry !== ec[k] || zero !== ez[k] || err !== ee[k] || c != k + 2) begin
                    bad++;
                    $display("FAIL arith_vec%0d: y=%h c=%b z=%b e=%b cyc=%0d, want y=%h c=%b z=%b e=%b cyc=%0d",
                             k, y, carry, zero, err, c, ey[k], ec[k], ez[k], ee[k], k + 2);
                end
                k++;
            end
            tick();
        end
        total++;
        if (k !== 8) begin
            bad++; $display("FAIL arith_count: got %0d results want 8", k);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] t_a [4];
        logic [7:0] t_b [4];
        logic [7:0] ey  [4];
        logic       ec  [4];
        logic       ez  [4];
        int i;
        int k;
        t_a = '{8'h01, 8'h10, 8'hFF, 8'h80};
        t_b = '{8'h01, 8'h20, 8'h02, 8'h80};
        ey  = '{8'h02, 8'h30, 8'h01, 8'h00};
        ec  = '{1'b0,  1'b0,  1'b1,  1'b1};
        ez  = '{1'b0,  1'b0,  1'b0,  1'b1};
        i = 0; k = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 5);
            in_valid  = (i < 4);
            op = 4'd6;
            if (i < 4) begin
                a = t_a[i]; b = t_b[i];
            end
            #1;
            if (c <= 5) begin
                total++;
                if (in_ready !== ((c < 2) || (c >= 5))) begin
                    bad++;
                    $display("FAIL bp_in_ready c=%0d: %b want %b", c, in_ready, ((c < 2) || (c >= 5)));
                end
            end
            if (c >= 2 && c <= 4) begin
                total++;
                if (out_valid !== 1'b1 || y !== 8'h02) begin
                    bad++;
                    $display("FAIL bp_stall_hold c=%0d: ov=%b y=%h want 1 02", c, out_valid, y);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (k >= 4) begin
                    bad++; $display("FAIL bp_duplicate: extra result y=%h", y);
                end else if (y !== ey[k] || carry !== ec[k] || zero !== ez[k] || err !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_result%0d: y=%h c=%b z=%b e=%b want y=%h c=%b z=%b e=0",
                             k, y, carry, zero, err, ey[k], ec[k], ez[k]);
                end
                k++;
            end
            if (in_valid && in_ready === 1'b1) i++;
            tick();
        end
        total++;
        if (k !== 4 || i !== 4) begin
            bad++; $display("FAIL bp_count: results=%0d accepted=%0d want 4 4", k, i);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_acc();
        logic [3:0] t_op [4];
        logic [7:0] t_a  [4];
        logic [7:0] ey   [4];
        logic       ec   [4];
        logic       ez   [4];
        logic       ee   [4];
        int i;
        int k;
`ifdef KATIO_ALU_ACC_EN
        t_op = '{4'd11, 4'd10, 4'd10, 4'd10};
        t_a  = '{8'h33, 8'h10, 8'hF5, 8'h01};
        ey   = '{8'h00, 8'h10, 8'h05, 8'h06};
        ec   = '{1'b0,  1'b0,  1'b1,  1'b0};
        ez   = '{1'b1,  1'b0,  1'b0,  1'b0};
        ee   = '{1'b0,  1'b0,  1'b0,  1'b0};
`else
        t_op = '{4'd11, 4'd10, 4'd10, 4'd10};
        t_a  = '{8'h33, 8'h10, 8'hF5, 8'h01};
        ey   = '{8'h00, 8'h00, 8'h00, 8'h00};
        ec   = '{1'b0,  1'b0,  1'b0,  1'b0};
        ez   = '{1'b1,  1'b1,  1'b1,  1'b1};
        ee   = '{1'b1,  1'b1,  1'b1,  1'b1};
`endif
        i = 0; k = 0;
        for (int c = 0; c < 24; c++) begin
            out_ready = (c % 2 == 1);
            in_valid  = (i < 4);
            if (i < 4) begin
                op = t_op[i]; a = t_a[i]; b = 8'h00;
            end
            #1;
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (k >= 4) begin
                    bad++; $display("FAIL acc_extra: unexpected result y=%h", y);
                end else if (y !== ey[k] || carry !== ec[k] || zero !== ez[k] || err !== ee[k]) begin
                    bad++;
                    $display("FAIL acc_beat%0d: y=%h c=%b z=%b e=%b want y=%h c=%b z=%b e=%b",
                             k, y, carry, zero, err, ey[k], ec[k], ez[k], ee[k]);
                end
                k++;
            end
            if (in_valid && in_ready === 1'b1) i++;
            tick();
        end
        total++;
        if (k !== 4) begin
            bad++; $display("FAIL acc_count: got %0d results want 4", k);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_gate_ops();
        test_arith_shift();
        test_backpressure();
        test_acc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
